// File: rtl/axi_ad7124_up_axi_if.sv
// AXI4-Lite bundle between a bus master and the AD7124 up-bus bridge.
interface axi_ad7124_up_axi_if #(
   parameter int AXI_ADDR_WIDTH = 16
);
   logic                      awvalid;
   logic                      awready;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic                      wvalid;
   logic                      wready;
   logic [31:0]               wdata;
   logic [3:0]                wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic                      rvalid;
   logic                      rready;
   logic [31:0]               rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_ad7124_up_axi.sv
// AXI4-Lite slave to up_* register-bus bridge with independent write/read FSMs.
// Optional ack timeout (SLVERR) enabled by defining AXI_AD7124_UP_TIMEOUT_EN.
module axi_ad7124_up_axi #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic               up_clk,
   input  logic               up_rstn,
   axi_ad7124_up_axi_if.slave s_axi,
   output logic               up_wreq,
   output logic [13:0]        up_waddr,
   output logic [31:0]        up_wdata,
   input  logic               up_wack,
   output logic               up_rreq,
   output logic [13:0]        up_raddr,
   input  logic [31:0]        up_rdata,
   input  logic               up_rack
);

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_e;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_req_t;

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic        aw_got_q, aw_got_d;
   logic        w_got_q, w_got_d;
   wr_req_t     pend_q, pend_d;
   wr_req_t     up_w_q, up_w_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [13:0] up_raddr_q, up_raddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic        awready, wready, arready;
   logic        aw_hs, w_hs;

`ifdef AXI_AD7124_UP_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  w_cnt_q, w_cnt_d;
   logic [7:0]  r_cnt_q, r_cnt_d;
`else
   logic [7:0]  unused_tmo;
   assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

   // Only awaddr/araddr[15:2] reach the register bus; strobes are ignored.
   logic [AXI_ADDR_WIDTH-1:0] unused_awaddr, unused_araddr;
   logic [3:0]                unused_wstrb;
   assign unused_awaddr = s_axi.awaddr;
   assign unused_araddr = s_axi.araddr;
   assign unused_wstrb  = s_axi.wstrb;

   // Write path: AW and W may arrive in either order or together.
   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      pend_d    = pend_q;
      up_w_d    = up_w_q;
      bresp_d   = bresp_q;
      awready   = 1'b0;
      wready    = 1'b0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
      w_cnt_d   = w_cnt_q;
`endif
      unique case (w_state_q)
         W_IDLE: begin
            awready = up_rstn & ~aw_got_q;
            wready  = up_rstn & ~w_got_q;
            aw_hs   = s_axi.awvalid & awready;
            w_hs    = s_axi.wvalid & wready;
            if (aw_hs) begin
               aw_got_d    = 1'b1;
               pend_d.addr = s_axi.awaddr[15:2];
            end
            if (w_hs) begin
               w_got_d     = 1'b1;
               pend_d.data = s_axi.wdata;
            end
            if ((aw_got_q | aw_hs) & (w_got_q | w_hs)) begin
               w_state_d   = W_REQ;
               aw_got_d    = 1'b0;
               w_got_d     = 1'b0;
               up_w_d.addr = aw_hs ? s_axi.awaddr[15:2] : pend_q.addr;
               up_w_d.data = w_hs ? s_axi.wdata : pend_q.data;
            end
         end
         W_REQ: begin
            w_state_d = W_WAIT;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
            w_cnt_d   = '0;
`endif
         end
         W_WAIT: begin
            if (up_wack) begin
               w_state_d = W_RESP;
               bresp_d   = 2'b00;
            end
`ifdef AXI_AD7124_UP_TIMEOUT_EN
            else if (w_cnt_q == TMO_LAST) begin
               w_state_d = W_RESP;
               bresp_d   = 2'b10;
            end else begin
               w_cnt_d = w_cnt_q + 8'd1;
            end
`endif
         end
         W_RESP: begin
            if (s_axi.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d  = r_state_q;
      up_raddr_d = up_raddr_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      arready    = 1'b0;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
      r_cnt_d    = r_cnt_q;
`endif
      unique case (r_state_q)
         R_IDLE: begin
            arready = up_rstn;
            if (s_axi.arvalid & arready) begin
               r_state_d  = R_REQ;
               up_raddr_d = s_axi.araddr[15:2];
            end
         end
         R_REQ: begin
            r_state_d = R_WAIT;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
            r_cnt_d   = '0;
`endif
         end
         R_WAIT: begin
            if (up_rack) begin
               r_state_d = R_RESP;
               rdata_d   = up_rdata;
               rresp_d   = 2'b00;
            end
`ifdef AXI_AD7124_UP_TIMEOUT_EN
            else if (r_cnt_q == TMO_LAST) begin
               r_state_d = R_RESP;
               rdata_d   = 32'hDEAD_DEAD;
               rresp_d   = 2'b10;
            end else begin
               r_cnt_d = r_cnt_q + 8'd1;
            end
`endif
         end
         R_RESP: begin
            if (s_axi.rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         pend_q     <= '0;
         up_w_q     <= '0;
         bresp_q    <= 2'b00;
         up_raddr_q <= '0;
         rdata_q    <= '0;
         rresp_q    <= 2'b00;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
         w_cnt_q    <= '0;
         r_cnt_q    <= '0;
`endif
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         pend_q     <= pend_d;
         up_w_q     <= up_w_d;
         bresp_q    <= bresp_d;
         up_raddr_q <= up_raddr_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
`ifdef AXI_AD7124_UP_TIMEOUT_EN
         w_cnt_q    <= w_cnt_d;
         r_cnt_q    <= r_cnt_d;
`endif
      end
   end

   assign s_axi.awready = awready;
   assign s_axi.wready  = wready;
   assign s_axi.bvalid  = (w_state_q == W_RESP);
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready;
   assign s_axi.rvalid  = (r_state_q == R_RESP);
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;

   assign up_wreq  = (w_state_q == W_REQ);
   assign up_waddr = up_w_q.addr;
   assign up_wdata = up_w_q.data;
   assign up_rreq  = (r_state_q == R_REQ);
   assign up_raddr = up_raddr_q;

endmodule

// File: tb/tb_axi_ad7124_up_axi.sv
// Self-checking bench: randomized AXI-Lite traffic against an up-bus target model
// and an address-indexed register model.
module tb_axi_ad7124_up_axi;
   localparam int AW  = 18;
   localparam int TMO = 32;

   logic up_clk = 1'b0;
   logic up_rstn = 1'b0;
   always #5 up_clk = ~up_clk;

   axi_ad7124_up_axi_if #(.AXI_ADDR_WIDTH(AW)) s_axi ();

   logic        up_wreq, up_rreq;
   logic [13:0] up_waddr, up_raddr;
   logic [31:0] up_wdata;
   logic        up_wack = 1'b0;
   logic        up_rack = 1'b0;
   logic [31:0] up_rdata = '0;

   axi_ad7124_up_axi #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .up_clk(up_clk), .up_rstn(up_rstn), .s_axi(s_axi),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge up_clk) cyc <= cyc + 1;

   // Target model: acks each request after a programmable delay.
   bit          tgt_en = 1'b1;
   int          wdly = 0, rdly = 0;
   int          wreq_cnt = 0, rreq_cnt = 0;
   int          last_wreq_cyc = -1, last_rreq_cyc = -1;
   logic [13:0] last_waddr = '0, last_raddr = '0;
   logic [31:0] last_wdata = '0;
   logic [31:0] tgt_mem [int];
   logic [31:0] model_mem [int];

   function automatic logic [31:0] pwr_on(int w);
      return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   always @(negedge up_clk) begin
      if (up_wreq) wreq_cnt <= wreq_cnt + 1;
      if (up_rreq) rreq_cnt <= rreq_cnt + 1;
   end

   initial forever begin
      @(negedge up_clk);
      if (up_wreq) begin
         last_wreq_cyc = cyc;
         last_waddr    = up_waddr;
         last_wdata    = up_wdata;
         if (tgt_en) begin
            tgt_mem[int'(up_waddr)] = up_wdata;
            repeat (wdly) @(posedge up_clk);
            @(posedge up_clk); #1 up_wack = 1'b1;
            @(posedge up_clk); #1 up_wack = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge up_clk);
      if (up_rreq) begin
         int a;
         a = int'(up_raddr);
         last_rreq_cyc = cyc;
         last_raddr    = up_raddr;
         if (tgt_en) begin
            repeat (rdly) @(posedge up_clk);
            @(posedge up_clk); #1 up_rack = 1'b1;
            up_rdata = tgt_mem.exists(a) ? tgt_mem[a] : pwr_on(a);
            @(posedge up_clk); #1 up_rack = 1'b0;
            up_rdata = $urandom;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic send_aw(input logic [AW-1:0] a, output int hs);
      s_axi.awaddr = a; s_axi.awvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge up_clk); if (s_axi.awready) break; end
      @(posedge up_clk); #1 hs = cyc;
      s_axi.awvalid = 1'b0; s_axi.awaddr = AW'($urandom);
   endtask

   task automatic send_w(input logic [31:0] d, output int hs);
      s_axi.wdata = d; s_axi.wstrb = 4'($urandom); s_axi.wvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge up_clk); if (s_axi.wready) break; end
      @(posedge up_clk); #1 hs = cyc;
      s_axi.wvalid = 1'b0; s_axi.wdata = $urandom;
   endtask

   task automatic send_ar(input logic [AW-1:0] a, output int hs);
      s_axi.araddr = a; s_axi.arvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin @(negedge up_clk); if (s_axi.arready) break; end
      @(posedge up_clk); #1 hs = cyc;
      s_axi.arvalid = 1'b0; s_axi.araddr = AW'($urandom);
   endtask

   task automatic wait_b(input int hold, output bit got, output bit stable,
                         output logic [1:0] resp, output int vcyc);
      got = 1'b0; stable = 1'b1; resp = 2'bxx; vcyc = -1;
      for (int i = 0; i < 200; i++) begin @(negedge up_clk); if (s_axi.bvalid) begin got = 1'b1; break; end end
      if (got) begin
         vcyc = cyc; resp = s_axi.bresp;
         repeat (hold) begin
            @(negedge up_clk);
            if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== resp) stable = 1'b0;
         end
         @(posedge up_clk); #1 s_axi.bready = 1'b1;
         @(posedge up_clk); #1 s_axi.bready = 1'b0;
      end
   endtask

   task automatic wait_r(input int hold, output bit got, output bit stable,
                         output logic [1:0] resp, output logic [31:0] data, output int vcyc);
      got = 1'b0; stable = 1'b1; resp = 2'bxx; data = 'x; vcyc = -1;
      for (int i = 0; i < 200; i++) begin @(negedge up_clk); if (s_axi.rvalid) begin got = 1'b1; break; end end
      if (got) begin
         vcyc = cyc; resp = s_axi.rresp; data = s_axi.rdata;
         repeat (hold) begin
            @(negedge up_clk);
            if (s_axi.rvalid !== 1'b1 || s_axi.rresp !== resp || s_axi.rdata !== data) stable = 1'b0;
         end
         @(posedge up_clk); #1 s_axi.rready = 1'b1;
         @(posedge up_clk); #1 s_axi.rready = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge up_clk);
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid, up_wreq, up_rreq,
           s_axi.bresp, s_axi.rresp, s_axi.rdata, up_waddr, up_raddr, up_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_state: outputs not all zero (rdata=%h waddr=%h raddr=%h wdata=%h rdy=%b)",
                  s_axi.rdata, up_waddr, up_raddr, up_wdata, {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      @(posedge up_clk); #1 up_rstn = 1'b1;
      @(negedge up_clk);
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_release: readies=%b expected 111", {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      @(posedge up_clk); #1;
   endtask

   task automatic test_write_gap();
      int ha, hw, bc, n0; bit got, st; logic [1:0] rs;
      wdly = 0; n0 = wreq_cnt;
      fork
         send_aw(18'h00040, ha);
         begin repeat (3) @(posedge up_clk); #1; send_w(32'h1234_5678, hw); end
      join
      wait_b(2, got, st, rs, bc);
      model_mem[16] = 32'h1234_5678;
      checks++;
      if (!got || !st || rs !== 2'b00) begin
         failures++; $display("FAIL write_gap_resp: got=%0d stable=%0d bresp=%b expected 1/1/00", got, st, rs);
      end
      checks++;
      if (wreq_cnt - n0 != 1 || last_waddr !== 14'h010 || last_wdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL write_gap_req: pulses=%0d waddr=%h wdata=%h expected 1/010/12345678",
                  wreq_cnt - n0, last_waddr, last_wdata);
      end
      checks++;
      if (up_waddr !== 14'h010 || up_wdata !== 32'h1234_5678) begin
         failures++; $display("FAIL write_hold: waddr=%h wdata=%h expected 010/12345678", up_waddr, up_wdata);
      end
   endtask

   task automatic test_read_hold();
      int h, rc; bit got, st; logic [1:0] rs; logic [31:0] rd;
      tgt_mem[0] = 32'h2020_0722; model_mem[0] = 32'h2020_0722; rdly = 0;
      send_ar(18'h00000, h);
      wait_r(5, got, st, rs, rd, rc);
      checks++;
      if (!got || !st || rs !== 2'b00 || rd !== 32'h2020_0722) begin
         failures++;
         $display("FAIL read_hold: got=%0d stable=%0d rresp=%b rdata=%h expected 1/1/00/20200722", got, st, rs, rd);
      end
      checks++;
      if (rc != h + 2 || last_raddr !== 14'h000) begin
         failures++; $display("FAIL read_latency: rvalid cycle=%0d expected %0d", rc, h + 2);
      end
   endtask

   task automatic test_latency();
      int ha, hw, bc; bit got, st; logic [1:0] rs; logic [31:0] d;
      wdly = 0; d = $urandom;
      fork send_aw(18'h00100, ha); send_w(d, hw); join
      wait_b(0, got, st, rs, bc);
      model_mem[64] = d;
      checks++;
      if (ha != hw || last_wreq_cyc != ha || bc != ha + 2) begin
         failures++;
         $display("FAIL write_latency: hs=%0d/%0d wreq=%0d bvalid=%0d expected wreq=hs bvalid=hs+2",
                  ha, hw, last_wreq_cyc, bc);
      end
      @(negedge up_clk);
      checks++;
      if (s_axi.bvalid !== 1'b0) begin
         failures++; $display("FAIL bvalid_drop: bvalid=%b expected 0 after handshake", s_axi.bvalid);
      end
      @(posedge up_clk); #1;
   endtask

   task automatic test_concurrent();
      int ha, hw, hr, bc, rc, nw, nr; bit gb, sb, gr, sr; logic [1:0] bs, rs; logic [31:0] d, rd, exp;
      d = $urandom; wdly = 1; rdly = 2; nw = wreq_cnt; nr = rreq_cnt;
      exp = model_mem.exists(2) ? model_mem[2] : pwr_on(2);
      fork send_aw(18'h00044, ha); send_w(d, hw); send_ar(18'h00008, hr); join
      fork wait_b(1, gb, sb, bs, bc); wait_r(2, gr, sr, rs, rd, rc); join
      model_mem[17] = d;
      checks++;
      if (last_wreq_cyc != last_rreq_cyc || last_wreq_cyc != ha || wreq_cnt - nw != 1 || rreq_cnt - nr != 1) begin
         failures++;
         $display("FAIL concurrent_req: wreq@%0d rreq@%0d pulses=%0d/%0d expected both @%0d once",
                  last_wreq_cyc, last_rreq_cyc, wreq_cnt - nw, rreq_cnt - nr, ha);
      end
      checks++;
      if (!gb || !sb || bs !== 2'b00 || last_waddr !== 14'h011 || last_wdata !== d) begin
         failures++; $display("FAIL concurrent_write: got=%0d bresp=%b waddr=%h expected 1/00/011", gb, bs, last_waddr);
      end
      checks++;
      if (!gr || !sr || rs !== 2'b00 || rd !== exp || last_raddr !== 14'h002) begin
         failures++; $display("FAIL concurrent_read: got=%0d rresp=%b rdata=%h expected 1/00/%h", gr, rs, rd, exp);
      end
   endtask

   task automatic test_ack_ignored();
      int ha, hw, bc; bit got, st, quiet; logic [1:0] rs;
      tgt_en = 1'b0;
      up_wack = 1'b1; up_rack = 1'b1; up_rdata = 32'hFFFF_0000;
      repeat (2) @(posedge up_clk); #1 up_wack = 1'b0; up_rack = 1'b0;
      @(negedge up_clk);
      checks++;
      if (s_axi.bvalid !== 1'b0 || s_axi.rvalid !== 1'b0 ||
          {s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
         failures++; $display("FAIL idle_ack: bvalid=%b rvalid=%b expected 0/0 with readies high",
                              s_axi.bvalid, s_axi.rvalid);
      end
      @(posedge up_clk); #1;
      fork send_aw(18'h00200, ha); send_w(32'hCAFE_0001, hw); join
      for (int i = 0; i < 10; i++) begin @(negedge up_clk); if (up_wreq) break; end
      up_wack = 1'b1;
      @(posedge up_clk); #1 up_wack = 1'b0;
      quiet = 1'b1;
      repeat (4) begin @(negedge up_clk); if (s_axi.bvalid !== 1'b0) quiet = 1'b0; end
      checks++;
      if (!quiet) begin
         failures++; $display("FAIL early_ack: bvalid=1 after ack in request cycle, expected 0");
      end
      @(posedge up_clk); #1 up_wack = 1'b1;
      @(posedge up_clk); #1 up_wack = 1'b0;
      wait_b(0, got, st, rs, bc);
      checks++;
      if (!got || rs !== 2'b00) begin
         failures++; $display("FAIL late_wack: got=%0d bresp=%b expected 1/00", got, rs);
      end
      model_mem[128] = 32'hCAFE_0001;
      tgt_mem[128] = 32'hCAFE_0001;
      tgt_en = 1'b1;
   endtask

   task automatic test_wait_limit();
      int h, rc; bit got, st; logic [1:0] rs; logic [31:0] rd;
      tgt_en = 1'b0;
      send_ar(18'h00004, h);
`ifdef AXI_AD7124_UP_TIMEOUT_EN
      rc = -1;
      for (int i = 0; i < TMO + 20; i++) begin @(negedge up_clk); if (s_axi.rvalid) begin rc = cyc; break; end end
      @(posedge up_clk); #1 up_rack = 1'b1; up_rdata = 32'h0BAD_F00D;
      @(posedge up_clk); #1 up_rack = 1'b0;
      wait_r(2, got, st, rs, rd, h);
      checks++;
      if (rc != last_rreq_cyc + TMO + 1) begin
         failures++; $display("FAIL timeout_cycle: rvalid@%0d expected %0d", rc, last_rreq_cyc + TMO + 1);
      end
      checks++;
      if (!got || !st || rs !== 2'b10 || rd !== 32'hDEAD_DEAD) begin
         failures++; $display("FAIL timeout_resp: got=%0d stable=%0d rresp=%b rdata=%h expected 1/1/10/deaddead",
                              got, st, rs, rd);
      end
`else
      st = 1'b1;
      repeat (60) begin @(negedge up_clk); if (s_axi.rvalid !== 1'b0) st = 1'b0; end
      checks++;
      if (!st) begin
         failures++; $display("FAIL wait_forever: rvalid=1 without ack, expected 0");
      end
      @(posedge up_clk); #1 up_rack = 1'b1; up_rdata = 32'h0BAD_F00D;
      @(posedge up_clk); #1 up_rack = 1'b0; up_rdata = 32'h0;
      wait_r(1, got, st, rs, rd, rc);
      checks++;
      if (!got || rs !== 2'b00 || rd !== 32'h0BAD_F00D) begin
         failures++; $display("FAIL wait_ack: got=%0d rresp=%b rdata=%h expected 1/00/0badf00d", got, rs, rd);
      end
`endif
      tgt_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int ha, hw, bc; bit got, st, quiet; logic [1:0] rs; logic [31:0] d;
      tgt_en = 1'b0;
      fork send_aw(18'h00080, ha); send_w(32'h5555_AAAA, hw); join
      repeat (3) @(posedge up_clk); #1 up_rstn = 1'b0;
      @(negedge up_clk);
      checks++;
      if ({s_axi.bvalid, s_axi.awready, s_axi.wready, s_axi.arready, up_wreq, up_waddr, up_wdata} !== '0) begin
         failures++; $display("FAIL reset_mid_state: bvalid=%b waddr=%h wdata=%h expected all zero",
                              s_axi.bvalid, up_waddr, up_wdata);
      end
      @(posedge up_clk); #1 up_rstn = 1'b1;
      @(negedge up_clk);
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
         failures++; $display("FAIL reset_mid_release: readies=%b expected 111", {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      quiet = 1'b1;
      repeat (10) begin @(negedge up_clk); if (s_axi.bvalid !== 1'b0) quiet = 1'b0; end
      checks++;
      if (!quiet) begin
         failures++; $display("FAIL reset_mid_noresp: bvalid asserted after abandoned write, expected 0");
      end
      tgt_en = 1'b1; wdly = 0; d = $urandom;
      @(posedge up_clk); #1;
      fork send_aw(18'h00084, ha); send_w(d, hw); join
      wait_b(0, got, st, rs, bc);
      model_mem[33] = d;
      checks++;
      if (!got || rs !== 2'b00 || last_waddr !== 14'h021 || last_wdata !== d) begin
         failures++; $display("FAIL reset_mid_next: got=%0d bresp=%b waddr=%h expected 1/00/021", got, rs, last_waddr);
      end
   endtask

   task automatic test_random();
      int words[$];
      for (int i = 0; i < 12; i++) begin
         logic [AW-1:0] a; logic [31:0] d; logic [1:0] rs;
         int g, bd, ha, hw, bc, n0, w; bit got, st;
         a = AW'($urandom); d = $urandom;
         g = int'($urandom_range(6, 0)) - 3; bd = int'($urandom_range(3, 0));
         wdly = int'($urandom_range(3, 0));
         w = (int'(a) / 4) % 16384;
         n0 = wreq_cnt;
         fork
            begin if (g < 0) begin repeat (-g) @(posedge up_clk); #1; end send_aw(a, ha); end
            begin if (g > 0) begin repeat (g) @(posedge up_clk); #1; end send_w(d, hw); end
         join
         wait_b(bd, got, st, rs, bc);
         model_mem[w] = d; words.push_back(w);
         checks++;
         if (!got || !st || rs !== 2'b00) begin
            failures++; $display("FAIL rand_wresp[%0d]: got=%0d stable=%0d bresp=%b expected 1/1/00", i, got, st, rs);
         end
         checks++;
         if (wreq_cnt - n0 != 1 || last_waddr !== 14'(w) || last_wdata !== d) begin
            failures++;
            $display("FAIL rand_wreq[%0d]: pulses=%0d waddr=%h wdata=%h expected 1/%h/%h",
                     i, wreq_cnt - n0, last_waddr, last_wdata, 14'(w), d);
         end
      end
      for (int i = 0; i < 10; i++) begin
         logic [AW-1:0] a; logic [31:0] rd, exp; logic [1:0] rs;
         int w, h, rc, hd, n0; bit got, st;
         if (i % 3 != 2) begin
            w = words[$urandom_range(words.size() - 1, 0)];
            a = AW'(w * 4 + int'($urandom_range(3, 0)) + 65536 * int'($urandom_range(3, 0)));
         end else begin
            a = AW'($urandom);
         end
         w = (int'(a) / 4) % 16384;
         exp = model_mem.exists(w) ? model_mem[w] : pwr_on(w);
         rdly = int'($urandom_range(3, 0)); hd = int'($urandom_range(3, 0));
         n0 = rreq_cnt;
         send_ar(a, h);
         wait_r(hd, got, st, rs, rd, rc);
         checks++;
         if (!got || !st || rs !== 2'b00 || rd !== exp || rreq_cnt - n0 != 1 || last_raddr !== 14'(w)) begin
            failures++;
            $display("FAIL rand_read[%0d]: addr=%h rresp=%b rdata=%h raddr=%h expected 00/%h/%h",
                     i, a, rs, rd, last_raddr, exp, 14'(w));
         end
      end
   endtask

   initial begin
      s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.wvalid = 1'b0; s_axi.wdata = '0;
      s_axi.wstrb = 4'hF; s_axi.bready = 1'b0; s_axi.arvalid = 1'b0; s_axi.araddr = '0;
      s_axi.rready = 1'b0;
      test_reset();
      test_write_gap();
      test_read_hold();
      test_latency();
      test_concurrent();
      test_ack_ignored();
      test_wait_limit();
      test_reset_mid();
      test_random();
      repeat (5) @(posedge up_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
